yasac_loader: RTL and testbench

- Host-side sequencer for the YASAC processor.
- Receives a program as a byte stream over a valid/ready handshake and writes it into program memory.
- Holds the processor in reset while loading, then pulses start, times the run until the processor reports ready, and reports status.
- Sits between a host link (UART/testbench) and the yasac top: drives its reset and start, and drives the program-memory write port.

---
 rtl/yasac_loader.sv | 151 +++++++++++++++
 tb/tb_yasac_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yasac_loader.sv
// rtl/yasac_loader.sv - host byte-stream program loader and run sequencer for YASAC
// Loads {hi,lo} words into program memory, then starts the CPU and times the run.
module yasac_loader #(
  parameter int AW = 8,
  parameter int CW = 16,
  parameter logic [CW-1:0] MAXCYC = CW'(16'hFFFF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          pm_we,
  output logic [AW-1:0] pm_addr,
  output logic [15:0]   pm_data,
  output logic          cpu_reset,
  output logic          cpu_start,
  input  logic          cpu_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] cycles,
  output logic [2:0]    state_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HI    = 3'd1,
    S_LO    = 3'd2,
    S_FLUSH = 3'd3,
    S_START = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int DEPTH = 1 << AW;

  state_t        state, state_nx;
  logic [7:0]    hi;
  logic [7:0]    left;
  logic [AW-1:0] idx;
  logic [CW-1:0] cycles_inc;
  logic          accept;
  logic          too_long;
  logic          ready_exit;
  logic          timeout;

  assign accept     = rx_valid & rx_ready;
  assign too_long   = {24'd0, rx_data} > 32'(DEPTH);
  assign cycles_inc = cycles + CW'(1);
  // cycles==0 marks the first RUN cycle, where ready is still the stale pre-start value
  assign ready_exit = (cycles != '0) && cpu_ready;
  assign timeout    = (cycles_inc == MAXCYC);
  assign state_out  = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rx_ready  = 1'b0;
    cpu_reset = 1'b1;
    cpu_start = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        rx_ready = 1'b1;
        if (state == S_DONE) cpu_reset = err;
        if (accept) begin
          if (rx_data == 8'd0) state_nx = S_START;
          else if (too_long)   state_nx = S_DONE;
          else                 state_nx = S_HI;
        end
      end
      S_HI: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = S_LO;
      end
      S_LO: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (accept) state_nx = (left == 8'd1) ? S_FLUSH : S_HI;
      end
      S_FLUSH: begin
        busy     = 1'b1;
        state_nx = S_START;
      end
      S_START: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        cpu_start = 1'b1;
        state_nx  = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        cpu_reset = 1'b0;
        if (ready_exit || timeout) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pm_we   <= 1'b0;
      pm_addr <= '0;
      pm_data <= '0;
      cycles  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      idx     <= '0;
      hi      <= '0;
      left    <= '0;
    end else begin
      pm_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            done <= 1'b0;
            err  <= too_long;
            idx  <= '0;
            left <= rx_data;
          end
        end
        S_HI: begin
          if (accept) hi <= rx_data;
        end
        S_LO: begin
          if (accept) begin
            pm_we   <= 1'b1;
            pm_addr <= idx;
            pm_data <= {hi, rx_data};
            idx     <= idx + AW'(1);
            left    <= left - 8'd1;
          end
        end
        S_START: cycles <= '0;
        S_RUN: begin
          cycles <= cycles_inc;
          if (ready_exit)   done <= 1'b1;
          else if (timeout) err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yasac_loader.sv
// tb/tb_yasac_loader.sv - scoreboard bench for yasac_loader
// Expected program writes are queued as bytes are sent and matched against pm_we pulses.
module tb_yasac_loader;

  localparam int AW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_data;
  logic          cpu_reset;
  logic          cpu_start;
  logic          cpu_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] cycles;
  logic [2:0]    state_out;

  yasac_loader #(.AW(AW), .CW(CW), .MAXCYC(16'd20)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_data(pm_data), .cpu_reset(cpu_reset),
    .cpu_start(cpu_start), .cpu_ready(cpu_ready), .busy(busy), .done(done), .err(err),
    .cycles(cycles), .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] sb[$];
  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] prog [0:15];
  int exp_idx;
  int n_start = 0;
  int exp_start = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // CPU model: ready high until first start, low from RUN cycle 1, high from RUN cycle ready_at
  int   ready_at;
  int   rc = 0;
  logic active = 1'b0;
  logic start_seen = 1'b0;
  always @(negedge clk) start_seen <= cpu_start;
  always @(posedge clk) begin
    if (start_seen) begin
      active <= 1'b1;
      rc     <= 1;
    end else if (active) rc <= rc + 1;
  end
  assign cpu_ready = !active ? 1'b1 : (ready_at != 0 && rc >= ready_at);

  always @(negedge clk) begin
    if (cpu_start) n_start++;
    if (pm_we) begin
      if (sb.size() == 0) check("extra_pm_we", 32'(pm_addr), 32'hFFFF_FFFF);
      else begin
        logic [23:0] e;
        e = sb.pop_front();
        check("pm_addr", 32'(pm_addr), 32'(e[23:16]));
        check("pm_data", 32'(pm_data), 32'(e[15:0]));
        mem[pm_addr] = pm_data;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int g);
    repeat (g) @(posedge clk);
    #1;
  endtask

  task automatic load(input int n, input int g);
    send(8'(n));
    exp_idx = 0;
    for (int i = 0; i < n; i++) begin
      if (i != 0) gap(g);
      send(prog[i][15:8]);
      gap(g);
      send(prog[i][7:0]);
      sb.push_back({8'(exp_idx), prog[i]});
      exp_idx++;
    end
    exp_start++;
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit);
    int n;
    n = 0;
    while (state_out !== s && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (state_out !== s) check("wait_state", 32'(state_out), 32'(s));
  endtask

  task automatic check_done_ok(input string tag, input int cyc);
    wait_state(3'd6, 200);
    check({tag, "_state"}, 32'(state_out), 32'd6);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cycles"}, 32'(cycles), 32'(cyc));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    ready_at = 10;
    for (int i = 0; i < (1<<AW); i++) mem[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_pm_we", 32'(pm_we), 32'd0);
    check("rst_pm_addr", 32'(pm_addr), 32'd0);
    check("rst_pm_data", 32'(pm_data), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_outs", {28'd0, rx_ready, cpu_reset, cpu_start, busy}, 32'b1100);
    reset = 1'b0;

    // 1+2: two-word load at full rate, run ends when ready rises in RUN cycle 10
    prog[0] = 16'h1234;
    prog[1] = 16'hABCD;
    load(2, 0);
    check("t1_flush_state", 32'(state_out), 32'd3);
    check("t1_flush_outs", {28'd0, rx_ready, cpu_reset, cpu_start, busy}, 32'b0101);
    @(posedge clk); #1;
    check("t1_start_state", 32'(state_out), 32'd4);
    check("t1_start_outs", {29'd0, cpu_reset, cpu_start, busy}, 32'b011);
    @(posedge clk); #1;
    check("t1_run_state", 32'(state_out), 32'd5);
    check("t1_run_start", 32'(cpu_start), 32'd0);
    check_done_ok("t2", 10);
    check("t2_starts", 32'(n_start), 32'(exp_start));

    // 3: zero length from IDLE runs the existing program
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h00);
    exp_start++;
    check("t3_start", 32'(state_out), 32'd4);
    check_done_ok("t3", 10);

    // 4: same load with three idle cycles between bytes; bytes held off during RUN
    load(2, 3);
    check("t4_flush", 32'(state_out), 32'd3);
    rx_data  = 8'h05;
    rx_valid = 1'b1;
    gap(4);
    check("t4_rx_blocked", 32'(state_out), 32'd5);
    rx_valid = 1'b0;
    check_done_ok("t4", 10);

    // 5: timeout with ready stuck low, then a new session clears err
    ready_at = 0;
    prog[0] = 16'h5A5A;
    load(1, 0);
    wait_state(3'd6, 200);
    check("t5_state", 32'(state_out), 32'd6);
    check("t5_err", 32'(err), 32'd1);
    check("t5_done", 32'(done), 32'd0);
    check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_cycles", 32'(cycles), 32'd20);
    send(8'h01);
    check("t5_new_state", 32'(state_out), 32'd1);
    check("t5_new_err", 32'(err), 32'd0);
    ready_at = 1;
    send(8'hC3);
    send(8'h3C);
    sb.push_back({8'd0, 16'hC33C});
    exp_start++;
    check_done_ok("t5_first_ready_ignored", 2);

    // 6: oversize length, then reset in the middle of a load
    send(8'd17);
    check("t6_len_state", 32'(state_out), 32'd6);
    check("t6_len_err", 32'(err), 32'd1);
    check("t6_len_done", 32'(done), 32'd0);
    send(8'd3);
    send(8'h11);
    send(8'h22);
    sb.push_back({8'd0, 16'h1122});
    send(8'h33);
    check("t6_in_lo", 32'(state_out), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_state", 32'(state_out), 32'd0);
    check("t6_rst_pm_we", 32'(pm_we), 32'd0);
    check("t6_rst_cycles", 32'(cycles), 32'd0);
    reset = 1'b0;
    gap(4);
    check("t6_mem0", 32'(mem[0]), 32'h1122);
    check("t6_mem1", 32'(mem[1]), 32'hABCD);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("starts_total", 32'(n_start), 32'(exp_start));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
